hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ==========================================================================
// hazard_ctrl : pipeline stall/flush/halt-drain control with event counters
// Revision 1.0
// ==========================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             control_j,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [2:0]       DRAIN_LOAD = 3'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic             halt_ack_q, halt_ack_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic raw_hit, rs1_hit, rs2_hit;
  logic pc_w, ifid_w, flush_w, bubble_w, stall_inc, flush_inc;

  always_comb begin
    rs1_hit = (id_rs1 != 5'd0) &&
              ((ex_reg_write && (ex_rd == id_rs1)) || (mem_reg_write && (mem_rd == id_rs1)));
    rs2_hit = id_uses_rs2 && (id_rs2 != 5'd0) &&
              ((ex_reg_write && (ex_rd == id_rs2)) || (mem_reg_write && (mem_rd == id_rs2)));
    raw_hit = id_valid && (rs1_hit || rs2_hit);
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    halt_ack_d = halt_ack_q;
    pc_w       = 1'b1;
    ifid_w     = 1'b1;
    flush_w    = 1'b0;
    bubble_w   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (raw_hit) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          bubble_w  = 1'b1;
          stall_inc = 1'b1;
        end else if (control_j) begin
          flush_w   = 1'b1;
          flush_inc = 1'b1;
          state_d   = S_FLUSH;
        end else if (halt_req) begin
          pc_w     = 1'b0;
          flush_w  = 1'b1;
          bubble_w = 1'b1;
          drain_d  = DRAIN_LOAD;
          // The request cycle itself is the first bubble, so one bubble needs no DRAIN visit.
          if (DRAIN_CYC <= 1) begin
            state_d    = S_HALTED;
            halt_ack_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_FLUSH: begin
        flush_w   = 1'b1;
        flush_inc = 1'b1;
        state_d   = S_RUN;
      end
      S_DRAIN: begin
        pc_w     = 1'b0;
        flush_w  = 1'b1;
        bubble_w = 1'b1;
        if (drain_q <= 3'd1) begin
          drain_d    = 3'd0;
          state_d    = S_HALTED;
          halt_ack_d = 1'b1;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      S_HALTED: begin
        pc_w     = 1'b0;
        ifid_w   = 1'b0;
        flush_w  = 1'b1;
        bubble_w = 1'b1;
        if (!halt_req) begin
          state_d    = S_RUN;
          halt_ack_d = 1'b0;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (cnt_clr)
      stall_cnt_d = '0;
    else if (stall_inc && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    else
      stall_cnt_d = stall_cnt_q;

    if (cnt_clr)
      flush_cnt_d = '0;
    else if (flush_inc && (flush_cnt_q != CNT_MAX))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    else
      flush_cnt_d = flush_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      drain_q     <= 3'd0;
      halt_ack_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      halt_ack_q  <= halt_ack_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Reset holds the front end frozen with NOPs injected until release.
  assign pc_write    = reset ? 1'b0 : pc_w;
  assign ifid_write  = reset ? 1'b0 : ifid_w;
  assign ifid_flush  = reset ? 1'b1 : flush_w;
  assign idex_bubble = reset ? 1'b1 : bubble_w;
  assign halt_ack    = halt_ack_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ==========================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        ex_reg_write, mem_reg_write;
  logic        control_j, halt_req, cnt_clr;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, halt_ack;
  logic [15:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYC(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write),
    .control_j(control_j), .halt_req(halt_req), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .halt_ack(halt_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; mem_rd = 0; ex_reg_write = 0; mem_reg_write = 0;
    control_j = 0; halt_req = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_fe(input string tag, input logic pcw, input logic ifw,
                          input logic fl, input logic bub);
    check({tag, ".pc_write"},    pcw == pc_write,    1);
    check({tag, ".ifid_write"},  ifw == ifid_write,  1);
    check({tag, ".ifid_flush"},  fl  == ifid_flush,  1);
    check({tag, ".idex_bubble"}, bub == idex_bubble, 1);
  endtask

  task automatic load_use_ex(input logic [4:0] r);
    id_valid = 1; id_rs1 = r; ex_rd = r; ex_reg_write = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    sample();
    check_fe("reset", 0, 0, 1, 1);
    check("reset.halt_ack", halt_ack, 0);
    check("reset.stall_cnt", stall_cnt, 0);
    check("reset.flush_cnt", flush_cnt, 0);
    tick();
    reset = 0;
    sample();
    check_fe("idle", 1, 1, 0, 0);

    // load-use against EX for one cycle
    tick();
    load_use_ex(5'd5);
    sample();
    check_fe("loaduse", 0, 0, 0, 1);
    tick();
    idle_inputs();
    sample();
    check_fe("loaduse.after", 1, 1, 0, 0);
    check("loaduse.stall_cnt", stall_cnt, 1);

    // x0 never hits; no-write never hits; invalid ID never hits
    tick();
    id_valid = 1; id_uses_rs2 = 1; id_rs1 = 5'd3; id_rs2 = 5'd0; ex_rd = 5'd0; ex_reg_write = 1;
    sample();
    check("x0.pc_write", pc_write, 1);
    tick();
    idle_inputs();
    id_valid = 1; id_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 0;
    sample();
    check("nowrite.pc_write", pc_write, 1);
    tick();
    idle_inputs();
    id_valid = 0; id_rs1 = 5'd9; ex_rd = 5'd9; ex_reg_write = 1;
    sample();
    check("invalid.bubble", idex_bubble, 0);
    tick();
    idle_inputs();
    sample();
    check("nohit.stall_cnt", stall_cnt, 1);

    // rs2 against MEM hits, rs2 ignored when unused
    tick();
    id_valid = 1; id_rs2 = 5'd9; mem_rd = 5'd9; mem_reg_write = 1; id_uses_rs2 = 0;
    sample();
    check("rs2unused.bubble", idex_bubble, 0);
    tick();
    id_uses_rs2 = 1;
    sample();
    check_fe("rs2mem", 0, 0, 0, 1);
    tick();
    idle_inputs();
    sample();
    check("rs2mem.stall_cnt", stall_cnt, 2);

    // jump: two consecutive flush cycles
    tick();
    control_j = 1;
    sample();
    check_fe("jump.c0", 1, 1, 1, 0);
    tick();
    control_j = 0;
    sample();
    check_fe("jump.c1", 1, 1, 1, 0);
    tick();
    sample();
    check_fe("jump.done", 1, 1, 0, 0);
    check("jump.flush_cnt", flush_cnt, 2);

    // raw_hit beats control_j; FLUSH ignores raw_hit
    tick();
    load_use_ex(5'd4);
    control_j = 1;
    sample();
    check_fe("simul.stall", 0, 0, 0, 1);
    tick();
    id_valid = 0;
    sample();
    check("simul.flush_cnt_held", flush_cnt, 2);
    check_fe("simul.jump", 1, 1, 1, 0);
    tick();
    control_j = 0;
    id_valid = 1;
    sample();
    check_fe("flush.ignores_raw", 1, 1, 1, 0);
    tick();
    idle_inputs();
    sample();
    check("simul.flush_cnt", flush_cnt, 4);
    check("simul.stall_cnt", stall_cnt, 3);

    // halt with request dropped mid-drain: ack on 3rd edge, leaves one edge later
    tick();
    halt_req = 1;
    sample();
    check_fe("halt.req", 0, 1, 1, 1);
    tick();
    sample();
    check("halt.e1.ack", halt_ack, 0);
    check("halt.e1.pc_write", pc_write, 0);
    tick();
    halt_req = 0;
    sample();
    check("halt.e2.ack", halt_ack, 0);
    check("halt.e2.bubble", idex_bubble, 1);
    tick();
    sample();
    check("halt.e3.ack", halt_ack, 1);
    check_fe("halted", 0, 0, 1, 1);
    tick();
    sample();
    check("halt.e4.ack", halt_ack, 0);
    check("halt.e4.pc_write", pc_write, 1);

    // halt held: HALTED persists until the request drops
    halt_req = 1;
    repeat (3) tick();
    sample();
    check("hold.ack", halt_ack, 1);
    tick();
    sample();
    check("hold.ack2", halt_ack, 1);
    halt_req = 0;
    tick();
    sample();
    check("hold.release.ack", halt_ack, 0);
    check_fe("hold.release", 1, 1, 0, 0);

    // reset mid-drain abandons the drain
    tick();
    halt_req = 1;
    tick();
    reset = 1;
    #2;
    check_fe("rstdrain", 0, 0, 1, 1);
    check("rstdrain.stall_cnt", stall_cnt, 0);
    check("rstdrain.flush_cnt", flush_cnt, 0);
    halt_req = 0;
    tick();
    reset = 0;
    sample();
    check_fe("rstdrain.run", 1, 1, 0, 0);
    tick();
    sample();
    check("rstdrain.run2.pc_write", pc_write, 1);
    check("rstdrain.run2.ack", halt_ack, 0);

    // saturation and clear priority
    load_use_ex(5'd12);
    repeat (65534) @(posedge clk);
    #1;
    check("sat.fffe", stall_cnt, 32'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat.ffff", stall_cnt, 32'hFFFF);
    cnt_clr = 1;
    sample();
    check("clr.stall_active", idex_bubble, 1);
    tick();
    idle_inputs();
    sample();
    check("clr.stall_cnt", stall_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
